// File: rtl/register_arbiter.sv
// Round-robin arbiter giving four requesters write access to one shared register,
// using a 4-phase req/ack handshake.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among pending requests
//   WRITE | winner's latched data presented with reg_load high for one cycle
//   ACK   | ack to winner held until it drops its request
module register_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       grant,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] reg_in,
  output logic             reg_load,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       ack_q, ack_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand_idx;
  logic [WIDTH-1:0] win_data;
  logic             owner_req;

  // Search starts at ptr and wraps, so the last winner gets lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand_idx  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand_idx = ptr_q + 2'(i);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data3;
    endcase
  end

  assign owner_req = |(req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = WRITE;
          grant_d = 4'b0001 << win_idx;
          ptr_d   = win_idx + 2'd1;
          data_d  = win_data;
        end
      end
      WRITE: begin
        state_d = ACK;
        ack_d   = grant_q;
      end
      ACK: begin
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ack_d   = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        ack_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      ack_q   <= 4'b0000;
      ptr_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  // reg_load decodes from state so reset removes it without waiting for a clock.
  assign grant    = grant_q;
  assign ack      = ack_q;
  assign reg_in   = data_q;
  assign reg_load = (state_q == WRITE);
  assign busy     = (state_q != IDLE);

endmodule
